// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit for the EX stage (MUL, MULHU, DIVU, REMU).
// Stalls the pipeline front end from the accept cycle until the registered result is ready.
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic [4:0]      rd_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] F3_MUL   = 3'b000;
   localparam logic [2:0] F3_MULHU = 3'b011;
   localparam logic [2:0] F3_DIVU  = 3'b101;
   localparam logic [2:0] F3_REMU  = 3'b111;

   state_t              r_state;
   logic [5:0]          r_count;
   logic [2:0]          r_funct3;
   logic [4:0]          r_rd;
   logic [XLEN-1:0]     r_opA;
   logic [XLEN-1:0]     r_opB;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN:0]       r_rem;
   logic [XLEN-1:0]     r_quot;
   logic [XLEN-1:0]     r_result;
   logic [4:0]          r_rdOut;
   logic                r_done;

   logic                w_supported;
   logic                w_accept;
   logic                w_lastIter;
   logic [XLEN:0]       w_sum;
   logic [2*XLEN-1:0]   w_accNext;
   logic [XLEN+1:0]     w_shifted;
   logic [XLEN+1:0]     w_trial;
   logic [XLEN:0]       w_remNext;
   logic [XLEN-1:0]     w_quotNext;
   logic [XLEN-1:0]     w_resultNext;

   always_comb begin
      w_supported = 1'b0;
      case (funct3_i)
         F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: w_supported = 1'b1;
         default:                            w_supported = 1'b0;
      endcase
   end

   assign w_accept   = start_i && w_supported && !flush_i;
   assign w_lastIter = (r_count == 6'(XLEN - 1));

   // Shift-add step: the upper half gathers partial sums, the lower half shifts out the multiplier.
   assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opA} : '0);
   assign w_accNext = {w_sum, r_acc[XLEN-1:1]};

   // Restoring step: a borrow out of the trial subtraction keeps the shifted remainder.
   assign w_shifted  = {r_rem, r_quot[XLEN-1]};
   assign w_trial    = w_shifted - {2'b00, r_opB};
   assign w_remNext  = w_trial[XLEN+1] ? w_shifted[XLEN:0] : w_trial[XLEN:0];
   assign w_quotNext = {r_quot[XLEN-2:0], ~w_trial[XLEN+1]};

   always_comb begin
      w_resultNext = w_accNext[XLEN-1:0];
      case (r_funct3)
         F3_MULHU: w_resultNext = w_accNext[2*XLEN-1:XLEN];
         F3_DIVU:  w_resultNext = w_quotNext;
         F3_REMU:  w_resultNext = w_remNext[XLEN-1:0];
         default:  w_resultNext = w_accNext[XLEN-1:0];
      endcase
   end

   // Control and datapath share one sequential block so the result is written on the final iteration.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_funct3 <= '0;
         r_rd     <= '0;
         r_opA    <= '0;
         r_opB    <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_quot   <= '0;
         r_result <= '0;
         r_rdOut  <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state  <= BUSY;
                  r_count  <= '0;
                  r_funct3 <= funct3_i;
                  r_rd     <= rd_i;
                  r_opA    <= op_a_i;
                  r_opB    <= op_b_i;
                  r_acc    <= {{XLEN{1'b0}}, op_b_i};
                  r_rem    <= '0;
                  r_quot   <= op_a_i;
               end
            end
            BUSY: begin
               if (flush_i) begin
                  r_state <= IDLE;
               end else begin
                  r_acc   <= w_accNext;
                  r_rem   <= w_remNext;
                  r_quot  <= w_quotNext;
                  r_count <= r_count + 6'd1;
                  if (w_lastIter) begin
                     r_state  <= DONE;
                     r_result <= w_resultNext;
                     r_rdOut  <= r_rd;
                     r_done   <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Freezing the front end already in the accept cycle keeps ID/EX from advancing under the unit.
   assign stall_o  = !rst_i && ((r_state == BUSY) || ((r_state == IDLE) && w_accept));
   assign done_o   = r_done;
   assign result_o = r_result;
   assign rd_o     = r_rdOut;

endmodule
